// File: rtl/pwm_capture_if.sv
// pwm_capture_if: groups the capture block's control, input waveform and
// measurement result signals.
//   en         capture enable (driven by master)
//   pwm_in     PWM waveform, asynchronous to clk (driven by master)
//   duty_out   last measured duty, 0..31 (driven by slave)
//   duty_valid one-clk pulse when duty_out/full_on update (driven by slave)
//   full_on    last frame had every sample high (driven by slave)
interface pwm_capture_if;
  logic       en;
  logic       pwm_in;
  logic [4:0] duty_out;
  logic       duty_valid;
  logic       full_on;

  modport master (output en, pwm_in, input duty_out, duty_valid, full_on);
  modport slave  (input en, pwm_in, output duty_out, duty_valid, full_on);
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures the duty of a 32-sample-period PWM waveform.
// The input is synchronized, sampled once every DIV clocks, aligned to a
// rising edge (or a 32-tick timeout) and then counted in 32-sample frames.
// Each completed frame produces a one-clk duty_valid pulse together with
// updated duty_out/full_on.
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   pif    pwm_capture_if slave: en, pwm_in in; duty_out, duty_valid, full_on out
module pwm_capture #(
  parameter int DIV = 4
) (
  input  logic          clk,
  input  logic          reset,
  pwm_capture_if.slave  pif
);
  localparam int CW = (DIV <= 2) ? 1 : $clog2(DIV);

  localparam logic [1:0] S_ALIGN   = 2'd0;
  localparam logic [1:0] S_MEASURE = 2'd1;
  localparam logic [1:0] S_REPORT  = 2'd2;

  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic          prev_q, prev_d;
  logic          prev_vld_q, prev_vld_d;
  logic [1:0]    state_q, state_d;
  logic [5:0]    frame_q, frame_d;
  logic [5:0]    high_q, high_d;
  logic [5:0]    algn_q, algn_d;
  logic [4:0]    duty_q, duty_d;
  logic          full_q, full_d;
  logic          dv_q, dv_d;
  logic          tick;
  logic [5:0]    high_inc;

  assign tick     = (tick_cnt_q == CW'(DIV - 1));
  assign high_inc = high_q + {5'd0, sync2_q};

  always_comb begin
    sync1_d    = pif.pwm_in;
    sync2_d    = sync1_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    prev_d     = tick ? sync2_q : prev_q;
    // prev_q only holds a real sample once a tick has loaded it since the
    // last enable/reset; until then no edge may be detected from it.
    prev_vld_d = prev_vld_q | tick;
    state_d    = state_q;
    frame_d    = frame_q;
    high_d     = high_q;
    algn_d     = algn_q;
    duty_d     = duty_q;
    full_d     = full_q;
    dv_d       = 1'b0;

    if (!pif.en) begin
      state_d    = S_ALIGN;
      frame_d    = '0;
      high_d     = '0;
      algn_d     = '0;
      prev_vld_d = 1'b0;
    end else begin
      case (state_q)
        S_ALIGN: if (tick) begin
          algn_d = algn_q + 6'd1;
          if (prev_vld_q && sync2_q && !prev_q) begin
            state_d = S_MEASURE;
            frame_d = 6'd1;
            high_d  = 6'd1;
            algn_d  = '0;
          end else if (algn_q == 6'd31) begin
            // 32nd tick without an edge: start a frame at an arbitrary phase
            state_d = S_MEASURE;
            frame_d = 6'd1;
            high_d  = {5'd0, sync2_q};
            algn_d  = '0;
          end
        end
        S_MEASURE: if (tick) begin
          frame_d = frame_q + 6'd1;
          high_d  = high_inc;
          if (frame_q == 6'd31) begin
            // results land together with the pulse so they are coherent in
            // the REPORT cycle
            state_d = S_REPORT;
            dv_d    = 1'b1;
            full_d  = (high_inc == 6'd32);
            duty_d  = (high_inc == 6'd32) ? 5'd31 : high_inc[4:0];
          end
        end
        S_REPORT: begin
          // DIV >= 2 guarantees no tick lands here
          state_d = S_MEASURE;
          frame_d = '0;
          high_d  = '0;
        end
        default: state_d = S_ALIGN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      tick_cnt_q <= '0;
      prev_q     <= 1'b0;
      prev_vld_q <= 1'b0;
      state_q    <= S_ALIGN;
      frame_q    <= '0;
      high_q     <= '0;
      algn_q     <= '0;
      duty_q     <= '0;
      full_q     <= 1'b0;
      dv_q       <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      tick_cnt_q <= tick_cnt_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      state_q    <= state_d;
      frame_q    <= frame_d;
      high_q     <= high_d;
      algn_q     <= algn_d;
      duty_q     <= duty_d;
      full_q     <= full_d;
      dv_q       <= dv_d;
    end
  end

  assign pif.duty_out   = duty_q;
  assign pif.full_on    = full_q;
  assign pif.duty_valid = dv_q;
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed bench for pwm_capture with DIV=4. A generator
// drives a 128-clk (32 samples x 4 clk) PWM period, or a constant level.
module tb_pwm_capture;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_duty = 10;
  int   gmode = 0;   // 0 periodic, 1 constant 0, 2 constant 1
  int   pos = 0;
  int   cyc;
  int   pulses;

  pwm_capture_if pif();

  pwm_capture #(.DIV(4)) dut (.clk(clk), .reset(reset), .pif(pif));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    pos = (pos == 127) ? 0 : pos + 1;
    case (gmode)
      0:       pif.pwm_in = (pos < n_duty * 4);
      1:       pif.pwm_in = 1'b0;
      default: pif.pwm_in = 1'b1;
    endcase
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  // Waits for the next duty_valid, sampled 1 time unit after each edge.
  task automatic wait_dv(input string tag, input int maxc, output int c);
    c = 0;
    do begin
      @(posedge clk); #1;
      c++;
    end while (!pif.duty_valid && c < maxc);
    chk({tag, "_seen"}, int'(pif.duty_valid), 1);
  endtask

  task automatic realign();
    @(negedge clk); pif.en = 1'b0;
    repeat (8) @(negedge clk);
    pif.en = 1'b1;
  endtask

  initial begin
    reset  = 1'b0;
    pif.en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_duty", int'(pif.duty_out), 0);
    chk("rst_full", int'(pif.full_on), 0);
    chk("rst_dv", int'(pif.duty_valid), 0);
    reset  = 1'b1;
    pif.en = 1'b1;

    // N=10 periodic
    wait_dv("n10_a", 700, cyc);
    chk("n10_a_duty", int'(pif.duty_out), 10);
    chk("n10_a_full", int'(pif.full_on), 0);
    wait_dv("n10_b", 200, cyc);
    chk("n10_b_period", cyc, 128);
    chk("n10_b_duty", int'(pif.duty_out), 10);

    // reset mid-frame (~17 samples in)
    repeat (68) @(posedge clk);
    @(negedge clk); reset = 1'b0; #1;
    chk("mrst_duty", int'(pif.duty_out), 0);
    chk("mrst_full", int'(pif.full_on), 0);
    chk("mrst_dv", int'(pif.duty_valid), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wait_dv("mrst_new", 700, cyc);
    chk("mrst_full_frame", int'(cyc >= 128), 1);
    chk("mrst_new_duty", int'(pif.duty_out), 10);

    // en low 50 clk mid-frame, N=31
    repeat (60) @(posedge clk);
    @(negedge clk); pif.en = 1'b0; n_duty = 31;
    pulses = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (pif.duty_valid) pulses++;
    end
    chk("en_lo_pulses", pulses, 0);
    chk("en_lo_hold", int'(pif.duty_out), 10);
    @(negedge clk); pif.en = 1'b1;
    wait_dv("en_n31", 700, cyc);
    chk("en_n31_duty", int'(pif.duty_out), 31);
    chk("en_n31_full", int'(pif.full_on), 0);

    // N changes 5 -> 20 mid-frame
    n_duty = 5;
    realign();
    wait_dv("n5", 700, cyc);
    chk("n5_duty", int'(pif.duty_out), 5);
    repeat (60) @(posedge clk);
    n_duty = 20;
    wait_dv("n5to20", 200, cyc);
    chk("n5to20_range", int'(pif.duty_out >= 5 && pif.duty_out <= 20), 1);
    wait_dv("n20", 200, cyc);
    chk("n20_duty", int'(pif.duty_out), 20);

    // constant 0: timeout path
    gmode = 1;
    realign();
    wait_dv("c0_a", 800, cyc);
    chk("c0_timeout", int'(cyc >= 240), 1);
    chk("c0_duty", int'(pif.duty_out), 0);
    chk("c0_full", int'(pif.full_on), 0);
    wait_dv("c0_b", 200, cyc);
    chk("c0_period", cyc, 128);

    // constant 1: timeout path, full on
    gmode = 2;
    realign();
    wait_dv("c1_a", 800, cyc);
    chk("c1_a_duty", int'(pif.duty_out), 31);
    chk("c1_a_full", int'(pif.full_on), 1);
    wait_dv("c1_b", 200, cyc);
    chk("c1_b_duty", int'(pif.duty_out), 31);
    chk("c1_b_full", int'(pif.full_on), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
